ex_pg_sequencer: RTL

Power-gating sequencer for the execute-stage multiplier and shifter. It consumes the per-instruction unit-usage hints from the decode stage (`mul_ins`/`sh_ins`) and sequences each unit's power switch and isolation: wake on demand, sleep after an idle window. While a required unit is not yet ready, it stalls issue. One independent state machine per unit, with optional inrush-limiting arbitration between them.

---
 rtl/ex_pg_sequencer_if.sv | 28 ++
 rtl/ex_pg_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ex_pg_sequencer_if.sv
// ex_pg_sequencer_if: decode-stage hints in, power-switch / isolation /
// stall controls out. The decode side uses master, the sequencer slave.
interface ex_pg_sequencer_if;
   logic ins_vld_i_pgs;
   logic mul_ins_i_pgs;
   logic sh_ins_i_pgs;
   logic mul_pwr_en_o_pgs;
   logic mul_iso_o_pgs;
   logic mul_rdy_o_pgs;
   logic sh_pwr_en_o_pgs;
   logic sh_iso_o_pgs;
   logic sh_rdy_o_pgs;
   logic stall_o_pgs;

   modport master (
      output ins_vld_i_pgs, mul_ins_i_pgs, sh_ins_i_pgs,
      input  mul_pwr_en_o_pgs, mul_iso_o_pgs, mul_rdy_o_pgs,
      input  sh_pwr_en_o_pgs, sh_iso_o_pgs, sh_rdy_o_pgs,
      input  stall_o_pgs
   );

   modport slave (
      input  ins_vld_i_pgs, mul_ins_i_pgs, sh_ins_i_pgs,
      output mul_pwr_en_o_pgs, mul_iso_o_pgs, mul_rdy_o_pgs,
      output sh_pwr_en_o_pgs, sh_iso_o_pgs, sh_rdy_o_pgs,
      output stall_o_pgs
   );
endinterface

// File: rtl/ex_pg_sequencer.sv
// ex_pg_sequencer: power-gating sequencer for the execute-stage multiplier
// and shifter. One FSM per unit: wake on demand, sleep after an idle window,
// isolation always asserted one cycle before power is removed.
//
// Optional feature macro: PGSEQ_INRUSH_LIMIT_EN
//   defined   -> at most one unit in WAKE at a time, multiplier has priority
//   undefined -> the two unit FSMs are fully independent
//
// state | meaning
// ------+-----------------------------------------------------------
// OFF   | switch open, isolated, unit unusable
// WAKE  | switch closed, still isolated while the rail settles
// ON    | powered and de-isolated; idle counter tracks non-use
// ISO   | isolated, still powered; one cycle before power-off
//       | (held longer only while an inrush-deferred request waits)
module ex_pg_sequencer #(
   parameter int WAKE_CYC = 4,    // >= 1
   parameter int IDLE_CYC = 16,   // >= 2
   parameter int CNT_W    = 5     // must hold max(WAKE_CYC, IDLE_CYC)
) (
   input logic               clk,
   input logic               rst_n,
   ex_pg_sequencer_if.slave  pgs
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_ISO  = 2'd3
   } pg_state_e;

   typedef struct packed {
      pg_state_e        st;
      logic [CNT_W-1:0] cnt;
   } unit_t;

   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
   // The compare sits one below IDLE_CYC-1 because the counter only clears
   // on the edge after a request: this puts ISO exactly IDLE_CYC cycles
   // after the last request.
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 2);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam unit_t            UNIT_RST  = '{st: ST_OFF, cnt: '0};

   unit_t mul_q, mul_d;
   unit_t sh_q,  sh_d;
   logic  mul_req, sh_req;
   logic  mul_grant, sh_grant;

   assign mul_req = pgs.ins_vld_i_pgs & pgs.mul_ins_i_pgs;
   assign sh_req  = pgs.ins_vld_i_pgs & pgs.sh_ins_i_pgs;

   // A blocked (grant=0) request leaves OFF/ISO units where they are.
   function automatic unit_t unit_next(input unit_t cur, input logic req,
                                       input logic grant);
      unit_t nxt;
      nxt = cur;
      case (cur.st)
         ST_OFF: begin
            if (req && grant) begin
               nxt.st  = ST_WAKE;
               nxt.cnt = '0;
            end
         end
         ST_WAKE: begin
            if (cur.cnt >= WAKE_LAST) begin
               nxt.st  = ST_ON;
               nxt.cnt = '0;
            end else begin
               nxt.cnt = cur.cnt + CNT_W'(1);
            end
         end
         ST_ON: begin
            if (req) begin
               nxt.cnt = '0;
            end else if (cur.cnt >= IDLE_LAST) begin
               nxt.st  = ST_ISO;
               nxt.cnt = '0;
            end else if (cur.cnt != CNT_MAX) begin
               nxt.cnt = cur.cnt + CNT_W'(1);
            end
         end
         ST_ISO: begin
            if (req) begin
               if (grant) begin
                  nxt.st  = ST_WAKE;
                  nxt.cnt = '0;
               end
            end else begin
               nxt.st  = ST_OFF;
               nxt.cnt = '0;
            end
         end
         default: nxt = UNIT_RST;
      endcase
      return nxt;
   endfunction

   // Next-state for both units; with inrush limiting the shifter only wakes
   // when the multiplier will not be in WAKE after this edge.
   always_comb begin
      mul_grant = 1'b1;
      sh_grant  = 1'b1;
`ifdef PGSEQ_INRUSH_LIMIT_EN
      mul_grant = !((sh_q.st == ST_WAKE) && (sh_q.cnt < WAKE_LAST));
`endif
      mul_d = unit_next(mul_q, mul_req, mul_grant);
`ifdef PGSEQ_INRUSH_LIMIT_EN
      sh_grant = (mul_d.st != ST_WAKE);
`endif
      sh_d = unit_next(sh_q, sh_req, sh_grant);
   end

   // State registers; reset forces both units OFF immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_q <= UNIT_RST;
         sh_q  <= UNIT_RST;
      end else begin
         mul_q <= mul_d;
         sh_q  <= sh_d;
      end
   end

   assign pgs.mul_pwr_en_o_pgs = (mul_q.st != ST_OFF);
   assign pgs.mul_iso_o_pgs    = (mul_q.st != ST_ON);
   assign pgs.mul_rdy_o_pgs    = (mul_q.st == ST_ON);
   assign pgs.sh_pwr_en_o_pgs  = (sh_q.st != ST_OFF);
   assign pgs.sh_iso_o_pgs     = (sh_q.st != ST_ON);
   assign pgs.sh_rdy_o_pgs     = (sh_q.st == ST_ON);

   assign pgs.stall_o_pgs = pgs.ins_vld_i_pgs &
                            ((pgs.mul_ins_i_pgs & ~pgs.mul_rdy_o_pgs) |
                             (pgs.sh_ins_i_pgs  & ~pgs.sh_rdy_o_pgs));

endmodule
